// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 signed max-pool of a snapshotted 6x6x3 map.
// Optional build macro CONV_MAXPOOL_RELU_EN clamps pooled values at zero.
module conv_maxpool #(
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [6*6*3*DW-1:0] conv_lin,
    output logic                busy,
    output logic                pool_vld,
    output logic [1:0]          pr_cnt,
    output logic [1:0]          pc_cnt,
    output logic [DW-1:0]       pool_D1,
    output logic [DW-1:0]       pool_D2,
    output logic [DW-1:0]       pool_D3,
    output logic                done,
    output logic [3*3*3*DW-1:0] pool_lin
);

    localparam int CW = 6*6*3*DW;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state, state_nxt;
    logic [3:0]           idx;
    logic [CW-1:0]        snap;
    logic [1:0]           pr, pc;
    logic [3:0]           pr_base;
    logic [2:0][DW-1:0]   res;
    logic [DW-1:0]        m;
    int                   base;
    logic                 load, step, last;

    function automatic logic [DW-1:0] elem(input logic [CW-1:0] v, input int e);
        return v[e*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    load      = 1'b1;
                end
            end
            SCAN: begin
                step = 1'b1;
                if (idx == 4'd8) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // raster window index -> pooled row/column
    always_comb begin
        pr = 2'd0;
        if (idx >= 4'd6)      pr = 2'd2;
        else if (idx >= 4'd3) pr = 2'd1;
        pr_base = {1'b0, pr, 1'b0} + {2'b00, pr};
        pc      = 2'(idx - pr_base);
    end

    always_comb begin
        res  = '0;
        m    = '0;
        base = 12*int'(pr) + 2*int'(pc);
        for (int ch = 0; ch < 3; ch++) begin
            m = smax(smax(elem(snap, ch*36 + base),     elem(snap, ch*36 + base + 1)),
                     smax(elem(snap, ch*36 + base + 6), elem(snap, ch*36 + base + 7)));
`ifdef CONV_MAXPOOL_RELU_EN
            if (m[DW-1]) m = '0;
`else
            m = m;
`endif
            res[ch] = m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            snap     <= '0;
            pool_lin <= '0;
            pool_D1  <= '0;
            pool_D2  <= '0;
            pool_D3  <= '0;
            pr_cnt   <= '0;
            pc_cnt   <= '0;
            pool_vld <= 1'b0;
            done     <= 1'b0;
        end else begin
            pool_vld <= step;
            done     <= last;
            if (load) begin
                snap <= conv_lin;
                idx  <= '0;
            end
            if (step) begin
                idx     <= idx + 4'd1;
                pr_cnt  <= pr;
                pc_cnt  <= pc;
                pool_D1 <= res[0];
                pool_D2 <= res[1];
                pool_D3 <= res[2];
                for (int ch = 0; ch < 3; ch++)
                    pool_lin[(ch*9 + int'(idx))*DW +: DW] <= res[ch];
            end
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: directed frames, queue-based monitor.
// Expected values follow CONV_MAXPOOL_RELU_EN when it is defined.
module tb_conv_maxpool;

    localparam int DW = 8;
    localparam int CW = 864;

    typedef logic [215:0] w_t;

    typedef struct {
        logic [1:0] pr;
        logic [1:0] pc;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic       last;
        w_t         lin;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] conv_lin;
    logic          busy;
    logic          pool_vld;
    logic [1:0]    pr_cnt;
    logic [1:0]    pc_cnt;
    logic [7:0]    pool_D1, pool_D2, pool_D3;
    logic          done;
    logic [215:0]  pool_lin;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;
    int   d0;

    conv_maxpool #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .conv_lin (conv_lin),
        .busy     (busy),
        .pool_vld (pool_vld),
        .pr_cnt   (pr_cnt),
        .pc_cnt   (pc_cnt),
        .pool_D1  (pool_D1),
        .pool_D2  (pool_D2),
        .pool_D3  (pool_D3),
        .done     (done),
        .pool_lin (pool_lin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- stimulus vectors and hand-derived expectations
    function automatic logic [CW-1:0] fill(input logic [7:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < 108; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [CW-1:0] ramp_in();
        logic [CW-1:0] r;
        for (int i = 0; i < 108; i++) r[i*8 +: 8] = 8'(i);
        return r;
    endfunction

    // window max is always the bottom-right element: ch*36+(2pr+1)*6+2pc+1
    function automatic w_t ramp_exp();
        w_t r;
        for (int ch = 0; ch < 3; ch++)
            for (int p = 0; p < 9; p++)
                r[(ch*9+p)*8 +: 8] = 8'(ch*36 + 12*(p/3) + 2*(p%3) + 7);
        return r;
    endfunction

    function automatic logic [CW-1:0] neg_in();
        logic [CW-1:0] r;
        for (int i = 0; i < 108; i++) r[i*8 +: 8] = 8'(100 - i);
        return r;
    endfunction

    // descending map: max is the top-left element, 100-(ch*36+12pr+2pc)
    function automatic w_t neg_exp();
        w_t r;
        for (int ch = 0; ch < 3; ch++)
            for (int p = 0; p < 9; p++)
                r[(ch*9+p)*8 +: 8] = 8'(100 - (ch*36 + 12*(p/3) + 2*(p%3)));
        return r;
    endfunction

    function automatic logic [CW-1:0] sgn_in();
        logic [CW-1:0] r;
        r = fill(8'h81);
        r[0*8 +: 8] = 8'hFB;
        r[1*8 +: 8] = 8'hFD;
        r[6*8 +: 8] = 8'h80;
        r[7*8 +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic w_t sgn_exp();
        w_t r;
`ifdef CONV_MAXPOOL_RELU_EN
        r = '0;
`else
        for (int i = 0; i < 27; i++) r[i*8 +: 8] = 8'h81;
        r[7:0] = 8'hFF;
`endif
        return r;
    endfunction

    // ---------------- driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [CW-1:0] vin, input w_t lin);
        exp_t e;
        conv_lin = vin;
        start    = 1'b1;
        for (int p = 0; p < 9; p++) begin
            e.pr   = 2'(p / 3);
            e.pc   = 2'(p % 3);
            e.d1   = lin[(0*9+p)*8 +: 8];
            e.d2   = lin[(1*9+p)*8 +: 8];
            e.d3   = lin[(2*9+p)*8 +: 8];
            e.last = (p == 8);
            e.lin  = lin;
            q.push_back(e);
        end
        tick();
        start = 1'b0;
        chk("busy_after_start", w_t'(busy), w_t'(1));
    endtask

    // ---------------- monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pool_vld) begin
                if (q.size() == 0) begin
                    chk("extra_vld", w_t'(pool_vld), w_t'(0));
                end else begin
                    e = q.pop_front();
                    chk("pr_cnt", w_t'(pr_cnt), w_t'(e.pr));
                    chk("pc_cnt", w_t'(pc_cnt), w_t'(e.pc));
                    chk("pool_D1", w_t'(pool_D1), w_t'(e.d1));
                    chk("pool_D2", w_t'(pool_D2), w_t'(e.d2));
                    chk("pool_D3", w_t'(pool_D3), w_t'(e.d3));
                    chk("lin_pos_ch0", w_t'(pool_lin[(0*9+e.pr*3+e.pc)*8 +: 8]), w_t'(e.d1));
                    chk("lin_pos_ch2", w_t'(pool_lin[(2*9+e.pr*3+e.pc)*8 +: 8]), w_t'(e.d3));
                    chk("done_flag", w_t'(done), w_t'(e.last));
                    if (e.last) chk("pool_lin_full", pool_lin, e.lin);
                end
            end else if (done) begin
                chk("done_without_vld", w_t'(done), w_t'(0));
            end
            if (done) n_done++;
        end
    end

    // ---------------- test sequence
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        conv_lin = '0;
        tick();
        tick();
        chk("reset_outs", w_t'({busy, pool_vld, done, pr_cnt, pc_cnt,
                               pool_D1, pool_D2, pool_D3}), w_t'(0));
        chk("reset_lin", pool_lin, w_t'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_quiet", w_t'({busy, pool_vld, done}), w_t'(0));
        end
        tick();

        // ramp frame
        d0 = n_done;
        start_frame(ramp_in(), ramp_exp());
        repeat (9) tick();
        tick();
        chk("busy_end", w_t'(busy), w_t'(0));
        chk("ramp_done_cnt", w_t'(n_done - d0), w_t'(1));

        // signed / relu frame
        start_frame(sgn_in(), sgn_exp());
        repeat (10) tick();

        // snapshot isolation and start ignored mid-scan
        d0 = n_done;
        start_frame(ramp_in(), ramp_exp());
        conv_lin = fill(8'h7F);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        tick();
        repeat (3) tick();
        chk("snap_done_cnt", w_t'(n_done - d0), w_t'(1));
        chk("snap_queue_empty", w_t'(q.size()), w_t'(0));

        // back-to-back frames: second start in the done cycle
        d0 = n_done;
        start_frame(ramp_in(), ramp_exp());
        repeat (9) tick();
        chk("b2b_done_cycle", w_t'(done), w_t'(1));
        start_frame(neg_in(), neg_exp());
        chk("b2b_old_pos8", w_t'(pool_lin[(2*9+8)*8 +: 8]), w_t'(107));
        repeat (9) tick();
        tick();
        chk("b2b_done_cnt", w_t'(n_done - d0), w_t'(2));

        // reset mid-frame
        start_frame(sgn_in(), sgn_exp());
        repeat (4) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", w_t'({busy, pool_vld, done, pr_cnt, pc_cnt,
                                   pool_D1, pool_D2, pool_D3}), w_t'(0));
        chk("async_rst_lin", pool_lin, w_t'(0));
        q.delete();
        d0 = n_done;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("abort_no_done", w_t'(n_done - d0), w_t'(0));
        chk("abort_idle", w_t'(busy), w_t'(0));

        start_frame(ramp_in(), ramp_exp());
        repeat (10) tick();
        chk("post_abort_done_cnt", w_t'(n_done - d0), w_t'(1));
        chk("final_queue_empty", w_t'(q.size()), w_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_maxpool.md
# conv_maxpool

Downstream stage of the 6×6×3 convolution result buffer. On a `start` pulse it snapshots the flattened 864-bit feature map and performs 2×2, stride-2 signed max-pooling on all three channels in parallel, one output position per cycle. It produces a 3×3×3 pooled map as a per-position stream and as a flattened, held bus for the next layer. Because the input is snapshotted, the result buffer can accept the next frame while pooling runs.

## Interface
Parameters:
- `DW`, 8, element width (signed two's complement).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  frame-ready pulse; sampled only in IDLE.
- `conv_lin`  in  6\*6\*3\*DW  flattened conv map.
  - Element (ch,r,c) sits at bits `[(ch*36+r*6+c)*DW +: DW]`.
- `busy`  out  1  high while in SCAN.
- `pool_vld`  out  1  `pr_cnt`/`pc_cnt`/`pool_D*` carry a valid position.
- `pr_cnt`  out  2  pooled row, 0..2.
- `pc_cnt`  out  2  pooled column, 0..2.
- `pool_D1`, `pool_D2`, `pool_D3`  out  DW each  pooled value, channels 0/1/2.
- `done`  out  1  one-cycle pulse coincident with the last `pool_vld`.
- `pool_lin`  out  3\*3\*3\*DW  flattened pooled map.
  - Element (ch,pr,pc) sits at bits `[(ch*9+pr*3+pc)*DW +: DW]`.

## Operation
- FSM has 2 states: IDLE and SCAN.
  - IDLE → SCAN on `start`=1. On the same edge, `conv_lin` is copied into the internal 864-bit snapshot `snap` and `idx` is cleared to 0.
  - In SCAN, each edge processes window `idx`:
    - pr = idx/3, pc = idx%3.
    - Window rows are 2pr and 2pr+1; window columns are 2pc and 2pc+1.
    - For each channel, the 4 elements are read from `snap` and reduced with a signed max (tree of 3 comparators).
    - Results are registered into `pool_D*`, `pr_cnt`, `pc_cnt`, and written into `pool_lin`.
    - `idx` increments.
  - SCAN → IDLE on the edge that processes idx=8.
- `start` is ignored while in SCAN. `snap` is unaffected by `conv_lin` changes after capture.
- Comparison is signed: 8'h80 (−128) is the smallest value, 8'h7F (+127) the largest. Equal values are allowed; there is no tie rule.
- `pool_lin` holds its values until the same position is overwritten in the next frame. It is never cleared by `start`.
- Outputs are retained between frames:
  - `pool_D*`, `pr_cnt`, `pc_cnt` hold their last values when `pool_vld`=0.
- Reset:
  - Asynchronous assertion forces IDLE and `idx`=0.
  - `snap`, `pool_lin`, `pool_D*`, `pr_cnt`, `pc_cnt` all reset to 0.
  - `busy`, `pool_vld`, `done` reset to 0.
  - Reset mid-SCAN aborts the frame. No `done` is produced, and the next frame requires a fresh `start`.

## Timing
- E0 is the edge sampling `start`=1 in IDLE.
- `busy`=1 during the cycles following E0 through E8 (9 cycles).
- Edge E(k+1) registers window k, for k=0..8:
  - `pool_vld`=1 during the cycles following E1 through E9.
  - Positions appear in raster order (0,0),(0,1),(0,2),(1,0)…(2,2).
- `done`=1 only in the cycle following E9, together with position (2,2).
  - `pool_lin` is complete in that same cycle.
- Latency from the `start` edge to the first valid output is 1 cycle; a full frame takes 9 cycles.
- Throughput:
  - A `start` asserted in the cycle following E8 is sampled at E9 while still in SCAN and is dropped.
  - A `start` in the cycle following E9 (the `done` cycle) is accepted at E10.
  - The minimum `start`-to-`start` spacing is therefore 10 cycles.

## Configuration
- `CONV_MAXPOOL_RELU_EN` defined: each pooled value becomes max(result, 0) before registering. Negative results output 8'h00.
- `CONV_MAXPOOL_RELU_EN` undefined: the raw signed max is output unchanged. Timing is identical in both builds.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
  - Release reset with `start`=0 for 20 cycles → `busy`/`pool_vld`/`done` stay 0.
- Ramp frame: `conv_lin` element (ch,r,c)=ch\*36+r\*6+c, then pulse `start`.
  - Expect 9 `pool_vld` cycles in raster order.
  - Position (0,0) gives D1=7, D2=43, D3=79; position (2,2) gives D1=35, D2=71, D3=107.
  - `done` coincides with (2,2); `pool_lin` matches.
- Signed/ReLU: channel 0 window (0,0) = {−5,−3,−128,−1}, all other elements 8'h81.
  - ReLU build: (0,0) D1=8'h00; every other output 8'h00.
  - Non-ReLU build: (0,0) D1=8'hFF; others 8'h81.
- Snapshot and start-ignore:
  - Change `conv_lin` to all 8'h7F one cycle after E0 → outputs still reflect the original frame.
  - Pulse `start` at E4 → no effect; still exactly 9 `pool_vld` cycles and one `done`.
- Back-to-back frames: pulse `start` in the `done` cycle with new data → second frame begins 1 cycle after the first `done`.
  - `pool_lin` positions update one by one from old to new values.
- Reset mid-operation: `rst_n` low after E4 → no `done`.
  - Next `start` produces a full, correct 9-position frame.
